// File: rtl/avalon_mm_arbiter_2to1_pkg.sv
// Shared types and constants for the two-master Avalon-MM arbiter.
package avalon_arb_pkg;

  localparam int unsigned DEF_ADDR_W      = 25;
  localparam int unsigned DEF_DATA_W      = 16;
  localparam int unsigned DEF_MAX_HOLD    = 8;
  localparam int unsigned DEF_MAX_PENDING = 4;
  localparam int unsigned CNT_W           = 8;
  localparam int unsigned ID_W            = 1;

  typedef logic [ID_W-1:0] master_id_t;

  localparam master_id_t M0 = 1'b0;
  localparam master_id_t M1 = 1'b1;

  // One-hot grant encoding; the state value drives the Grant port directly
  typedef enum logic [1:0] {
    GRANT_NONE = 2'b00,
    GRANT_M0   = 2'b01,
    GRANT_M1   = 2'b10
  } grant_t;

  function automatic grant_t grant_of(input master_id_t id);
    return (id == M1) ? GRANT_M1 : GRANT_M0;
  endfunction

  function automatic master_id_t other_of(input master_id_t id);
    return (id == M1) ? M0 : M1;
  endfunction

endpackage

// File: rtl/avalon_mm_arbiter_2to1_if.sv
// One Avalon-MM port: master drives the command, slave returns stall and read data.
interface avalon_mm_arbiter_2to1_if #(
  parameter int unsigned ADDR_W = avalon_arb_pkg::DEF_ADDR_W,
  parameter int unsigned DATA_W = avalon_arb_pkg::DEF_DATA_W
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic [ADDR_W-1:0] Address;
  logic [BE_W-1:0]   ByteEnable;
  logic              Write;
  logic [DATA_W-1:0] WriteData;
  logic              Read;
  logic              WaitRequest;
  logic [DATA_W-1:0] ReadData;
  logic              ReadDataValid;

  modport master (
    output Address, ByteEnable, Write, WriteData, Read,
    input  WaitRequest, ReadData, ReadDataValid
  );

  modport slave (
    input  Address, ByteEnable, Write, WriteData, Read,
    output WaitRequest, ReadData, ReadDataValid
  );

endinterface

// File: rtl/avalon_mm_arbiter_2to1_read_id_fifo.sv
// In-order FIFO of master IDs for outstanding reads; extra pointer bit tells full from empty.
module read_id_fifo
  import avalon_arb_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_MAX_PENDING,
  parameter int unsigned W     = ID_W
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PTR_W = AW + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head    = mem[rd_ptr[AW-1:0]];

  // Pointer update; reset discards all pending IDs
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Storage write; contents are don't-care until pushed
  always_ff @(posedge Clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/avalon_mm_arbiter_2to1.sv
// Round-robin 2:1 Avalon-MM arbiter with bounded grant hold and read-return steering.
module avalon_mm_arbiter_2to1
  import avalon_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned MAX_HOLD    = DEF_MAX_HOLD,
  parameter int unsigned MAX_PENDING = DEF_MAX_PENDING
) (
  input  logic                      Clk,
  input  logic                      Reset,
  avalon_mm_arbiter_2to1_if.slave   m0,
  avalon_mm_arbiter_2to1_if.slave   m1,
  avalon_mm_arbiter_2to1_if.master  s,
  output logic                      S_ChipEnable,
  output logic [1:0]                Grant,
  output logic                      Orphan_Error
);

  localparam int unsigned BE_W = DATA_W / 8;

  grant_t           state;
  grant_t           state_nxt;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] hold_cnt_nxt;
  master_id_t       last_id;
  master_id_t       last_id_nxt;

  logic              owned;
  master_id_t        owner_id;
  logic              req0;
  logic              req1;
  logic              own_req;
  logic              other_req;
  logic              own_write;
  logic              own_read;
  logic [ADDR_W-1:0] own_addr;
  logic [BE_W-1:0]   own_be;
  logic [DATA_W-1:0] own_wdata;
  logic              s_rd;
  logic              s_wr;
  logic              accept;

  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  master_id_t        fifo_head;

  // Owner decode; a read+write on one master is treated as a write
  assign owned     = (state != GRANT_NONE);
  assign owner_id  = (state == GRANT_M1) ? M1 : M0;
  assign req0      = m0.Read | m0.Write;
  assign req1      = m1.Read | m1.Write;
  assign own_req   = (owner_id == M1) ? req1 : req0;
  assign other_req = (owner_id == M1) ? req0 : req1;
  assign own_write = owned & ((owner_id == M1) ? m1.Write : m0.Write);
  assign own_read  = owned & ~own_write & ((owner_id == M1) ? m1.Read : m0.Read);
  assign own_addr  = (owner_id == M1) ? m1.Address    : m0.Address;
  assign own_be    = (owner_id == M1) ? m1.ByteEnable : m0.ByteEnable;
  assign own_wdata = (owner_id == M1) ? m1.WriteData  : m0.WriteData;
  assign s_rd      = own_read & ~fifo_full;
  assign s_wr      = own_write;
  assign accept    = (s_rd | s_wr) & ~s.WaitRequest;
  assign fifo_pop  = s.ReadDataValid & ~fifo_empty;
  assign Grant     = state;

  // Grant state, hold counter and last-served register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= GRANT_NONE;
      hold_cnt <= '0;
      last_id  <= M1;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
      last_id  <= last_id_nxt;
    end
  end

  // Next grant: release on idle owner, rotate after MAX_HOLD accepts if the other waits
  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    last_id_nxt  = last_id;
    if (!owned) begin
      hold_cnt_nxt = '0;
      if (req0 && req1) begin
        state_nxt   = grant_of(other_of(last_id));
        last_id_nxt = other_of(last_id);
      end else if (req0) begin
        state_nxt   = GRANT_M0;
        last_id_nxt = M0;
      end else if (req1) begin
        state_nxt   = GRANT_M1;
        last_id_nxt = M1;
      end
    end else if (!own_req) begin
      hold_cnt_nxt = '0;
      if (other_req) begin
        state_nxt   = grant_of(other_of(owner_id));
        last_id_nxt = other_of(owner_id);
      end else begin
        state_nxt = GRANT_NONE;
      end
    end else if (accept) begin
      if (hold_cnt == CNT_W'(MAX_HOLD - 1)) begin
        hold_cnt_nxt = '0;
        if (other_req) begin
          state_nxt   = grant_of(other_of(owner_id));
          last_id_nxt = other_of(owner_id);
        end
      end else begin
        hold_cnt_nxt = hold_cnt + CNT_W'(1);
      end
    end
  end

  // Bus muxing, stall steering and read-return routing
  always_comb begin
    s.Address        = '0;
    s.ByteEnable     = '0;
    s.WriteData      = '0;
    s.Read           = 1'b0;
    s.Write          = 1'b0;
    S_ChipEnable     = 1'b0;
    m0.WaitRequest   = 1'b1;
    m1.WaitRequest   = 1'b1;
    m0.ReadData      = s.ReadData;
    m1.ReadData      = s.ReadData;
    m0.ReadDataValid = fifo_pop & (fifo_head == M0);
    m1.ReadDataValid = fifo_pop & (fifo_head == M1);
    if (owned) begin
      s.Address    = own_addr;
      s.ByteEnable = own_be;
      s.WriteData  = own_wdata;
      s.Read       = s_rd;
      s.Write      = s_wr;
      S_ChipEnable = 1'b1;
      if (owner_id == M1) m1.WaitRequest = s.WaitRequest | (own_read & fifo_full);
      else                m0.WaitRequest = s.WaitRequest | (own_read & fifo_full);
    end
  end

  // Sticky flag for read data arriving with nothing outstanding
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Orphan_Error <= 1'b0;
    end else if (s.ReadDataValid && fifo_empty) begin
      Orphan_Error <= 1'b1;
    end
  end

  read_id_fifo #(
    .DEPTH (MAX_PENDING),
    .W     (ID_W)
  ) u_read_id_fifo (
    .Clk   (Clk),
    .Reset (Reset),
    .push  (accept & s_rd),
    .pop   (s.ReadDataValid),
    .din   (owner_id),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

endmodule

// File: tb/tb_avalon_mm_arbiter_2to1.sv
// Directed bench for the 2:1 Avalon-MM arbiter: per-cycle vector table plus multi-cycle sequences.
module tb_avalon_mm_arbiter_2to1;
  import avalon_arb_pkg::*;

  logic       Clk;
  logic       Reset;
  logic       S_ChipEnable;
  logic [1:0] Grant;
  logic       Orphan_Error;

  avalon_mm_arbiter_2to1_if m0_if ();
  avalon_mm_arbiter_2to1_if m1_if ();
  avalon_mm_arbiter_2to1_if s_if ();

  avalon_mm_arbiter_2to1 dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .m0           (m0_if),
    .m1           (m1_if),
    .s            (s_if),
    .S_ChipEnable (S_ChipEnable),
    .Grant        (Grant),
    .Orphan_Error (Orphan_Error)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct packed {
    logic       r0, w0, r1, w1, sw, srdv;
    logic [1:0] g;
    logic       wr0, wr1, sr, swr, ce, rdv0, rdv1;
  } vec_t;

  vec_t vt [14];

  int n_chk  = 0;
  int n_pass = 0;

  logic [1:0]  lg_g    [64];
  logic [24:0] lg_addr [64];
  logic [15:0] lg_data [64];
  logic        lg_wr   [64];
  logic        wr1_log [64];
  int          who_q [$];
  logic [15:0] dat_q [$];
  int          acc0;
  int          acc1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic idle_inputs();
    m0_if.Read = 0; m0_if.Write = 0; m0_if.Address = '0; m0_if.ByteEnable = '1; m0_if.WriteData = '0;
    m1_if.Read = 0; m1_if.Write = 0; m1_if.Address = '0; m1_if.ByteEnable = '1; m1_if.WriteData = '0;
    s_if.WaitRequest = 0; s_if.ReadData = '0; s_if.ReadDataValid = 0;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    idle_inputs();
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
  endtask

  // Write masters advance only when their own WaitRequest is low
  task automatic run_writes(input int n0, input bit m1_on, input int st0, input int stlen, input int ncyc);
    int i0 = 0;
    int i1 = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge Clk);
      m0_if.Write     = (i0 < n0);
      m0_if.Address   = 25'(i0);
      m0_if.WriteData = 16'hA000 | 16'(i0);
      m1_if.Write     = m1_on;
      m1_if.Address   = 25'h100000 + 25'(i1);
      m1_if.WriteData = 16'hB000 | 16'(i1);
      s_if.WaitRequest = (c >= st0) && (c < st0 + stlen);
      #1;
      lg_g[c]    = Grant;
      lg_addr[c] = s_if.Address;
      lg_data[c] = s_if.WriteData;
      lg_wr[c]   = s_if.Write;
      if (m0_if.Write && !m0_if.WaitRequest) i0++;
      if (m1_if.Write && !m1_if.WaitRequest) i1++;
    end
    idle_inputs();
  endtask

  // Read masters plus a fixed-latency slave returning D000, D001, ...
  task automatic run_reads(input int n0, input int s0, input int n1, input int s1, input int lat, input int ncyc);
    int ret_q [$];
    int nret = 0;
    acc0 = 0;
    acc1 = 0;
    who_q.delete();
    dat_q.delete();
    for (int c = 0; c < ncyc; c++) begin
      @(negedge Clk);
      m0_if.Read    = (c >= s0) && (acc0 < n0);
      m0_if.Address = 25'(acc0);
      m1_if.Read    = (c >= s1) && (acc1 < n1);
      m1_if.Address = 25'h1000 + 25'(acc1);
      s_if.WaitRequest   = 1'b0;
      s_if.ReadDataValid = (ret_q.size() > 0) && (ret_q[0] == c);
      s_if.ReadData      = 16'hD000 + 16'(nret);
      #1;
      wr1_log[c] = m1_if.WaitRequest;
      if (m0_if.ReadDataValid || m1_if.ReadDataValid) begin
        who_q.push_back((m0_if.ReadDataValid && m1_if.ReadDataValid) ? 2 : (m1_if.ReadDataValid ? 1 : 0));
        dat_q.push_back(m1_if.ReadDataValid ? m1_if.ReadData : m0_if.ReadData);
      end
      if (s_if.ReadDataValid) begin
        void'(ret_q.pop_front());
        nret++;
      end
      if (m0_if.Read && !m0_if.WaitRequest) begin acc0++; ret_q.push_back(c + lat); end
      if (m1_if.Read && !m1_if.WaitRequest) begin acc1++; ret_q.push_back(c + lat); end
    end
    idle_inputs();
  endtask

  initial begin
    int b;
    int p;
    int idx;
    int exp_who [4];

    // r0 w0 r1 w1 sw srdv | grant wr0 wr1 sr swr ce rdv0 rdv1
    vt[0]  = '{0,0,0,0,0,0, 2'b00, 1,1,0,0,0,0,0};
    vt[1]  = '{0,1,0,1,0,0, 2'b00, 1,1,0,0,0,0,0};
    vt[2]  = '{0,1,0,1,0,0, 2'b01, 0,1,0,1,1,0,0};
    vt[3]  = '{0,1,0,1,1,0, 2'b01, 1,1,0,1,1,0,0};
    vt[4]  = '{0,0,0,1,0,0, 2'b01, 0,1,0,0,1,0,0};
    vt[5]  = '{0,0,1,0,0,0, 2'b10, 1,0,1,0,1,0,0};
    vt[6]  = '{0,0,1,1,0,0, 2'b10, 1,0,0,1,1,0,0};
    vt[7]  = '{0,0,0,0,0,1, 2'b10, 1,0,0,0,1,0,1};
    vt[8]  = '{0,0,0,0,0,0, 2'b00, 1,1,0,0,0,0,0};
    vt[9]  = '{1,0,1,0,0,0, 2'b00, 1,1,0,0,0,0,0};
    vt[10] = '{1,0,1,0,0,0, 2'b01, 0,1,1,0,1,0,0};
    vt[11] = '{0,0,1,0,0,1, 2'b01, 0,1,0,0,1,1,0};
    vt[12] = '{0,0,0,0,0,0, 2'b10, 1,0,0,0,1,0,0};
    vt[13] = '{0,0,0,0,0,0, 2'b00, 1,1,0,0,0,0,0};

    Reset = 1'b1;
    idle_inputs();
    do_reset();

    // Reset state
    @(negedge Clk); #1;
    chk("reset_grant", 32'(Grant), 32'h0);
    chk("reset_wait0", 32'(m0_if.WaitRequest), 32'h1);
    chk("reset_wait1", 32'(m1_if.WaitRequest), 32'h1);
    chk("reset_ce", 32'(S_ChipEnable), 32'h0);
    chk("reset_orphan", 32'(Orphan_Error), 32'h0);

    // Vector table, one cycle per record
    for (int i = 0; i < 14; i++) begin
      @(negedge Clk);
      m0_if.Read = vt[i].r0; m0_if.Write = vt[i].w0;
      m1_if.Read = vt[i].r1; m1_if.Write = vt[i].w1;
      s_if.WaitRequest = vt[i].sw; s_if.ReadDataValid = vt[i].srdv;
      #1;
      chk($sformatf("vec%0d_grant", i), 32'(Grant), 32'(vt[i].g));
      chk($sformatf("vec%0d_wait0", i), 32'(m0_if.WaitRequest), 32'(vt[i].wr0));
      chk($sformatf("vec%0d_wait1", i), 32'(m1_if.WaitRequest), 32'(vt[i].wr1));
      chk($sformatf("vec%0d_sread", i), 32'(s_if.Read), 32'(vt[i].sr));
      chk($sformatf("vec%0d_swrite", i), 32'(s_if.Write), 32'(vt[i].swr));
      chk($sformatf("vec%0d_ce", i), 32'(S_ChipEnable), 32'(vt[i].ce));
      chk($sformatf("vec%0d_rdv0", i), 32'(m0_if.ReadDataValid), 32'(vt[i].rdv0));
      chk($sformatf("vec%0d_rdv1", i), 32'(m1_if.ReadDataValid), 32'(vt[i].rdv1));
    end
    idle_inputs();

    // M0 alone writes 20 words
    do_reset();
    run_writes(20, 1'b0, -1, 0, 23);
    chk("solo_grant_c0", 32'(lg_g[0]), 32'h0);
    for (int c = 1; c <= 20; c++) begin
      chk($sformatf("solo_grant_c%0d", c), 32'(lg_g[c]), 32'h1);
      chk($sformatf("solo_addr_c%0d", c), 32'(lg_addr[c]), 32'(c - 1));
    end
    chk("solo_data_c20", 32'(lg_data[20]), 32'hA013);
    chk("solo_write_c21", 32'(lg_wr[21]), 32'h0);
    chk("solo_grant_c22", 32'(lg_g[22]), 32'h0);

    // Both write continuously: grant rotates every 8 accepts
    do_reset();
    run_writes(1000, 1'b1, -1, 0, 41);
    chk("hold_grant_c0", 32'(lg_g[0]), 32'h0);
    for (int c = 1; c < 41; c++) begin
      b = (c - 1) / 8;
      p = (c - 1) % 8;
      idx = (b / 2) * 8 + p;
      chk($sformatf("hold_grant_c%0d", c), 32'(lg_g[c]), (b % 2 == 0) ? 32'h1 : 32'h2);
      chk($sformatf("hold_addr_c%0d", c), 32'(lg_addr[c]), (b % 2 == 0) ? 32'(idx) : 32'h100000 + 32'(idx));
      chk($sformatf("hold_data_c%0d", c), 32'(lg_data[c]), (b % 2 == 0) ? 32'hA000 + 32'(idx) : 32'hB000 + 32'(idx));
    end

    // Slave stall of 10 cycles mid-burst freezes bus and hold count
    do_reset();
    run_writes(1000, 1'b1, 4, 10, 21);
    for (int c = 1; c <= 18; c++) begin
      chk($sformatf("stall_grant_c%0d", c), 32'(lg_g[c]), 32'h1);
      chk($sformatf("stall_addr_c%0d", c), 32'(lg_addr[c]), (c < 4) ? 32'(c - 1) : ((c < 14) ? 32'h3 : 32'(c - 11)));
      chk($sformatf("stall_data_c%0d", c), 32'(lg_data[c]), (c < 4) ? 32'hA000 + 32'(c - 1) : ((c < 14) ? 32'hA003 : 32'hA000 + 32'(c - 11)));
    end
    chk("stall_grant_c19", 32'(lg_g[19]), 32'h2);
    chk("stall_addr_c19", 32'(lg_addr[19]), 32'h100000);
    chk("stall_addr_c20", 32'(lg_addr[20]), 32'h100001);

    // M1 issues 6 reads against 4-deep tracking, slave latency 5
    do_reset();
    run_reads(0, 0, 6, 0, 5, 16);
    chk("rd6_acc1", 32'(acc1), 32'd6);
    chk("rd6_wait_c0", 32'(wr1_log[0]), 32'h1);
    for (int c = 1; c <= 4; c++) chk($sformatf("rd6_wait_c%0d", c), 32'(wr1_log[c]), 32'h0);
    chk("rd6_wait_c5", 32'(wr1_log[5]), 32'h1);
    chk("rd6_wait_c6", 32'(wr1_log[6]), 32'h1);
    chk("rd6_wait_c7", 32'(wr1_log[7]), 32'h0);
    chk("rd6_wait_c8", 32'(wr1_log[8]), 32'h0);
    chk("rd6_rdv_count", 32'(who_q.size()), 32'd6);
    for (int i = 0; i < who_q.size() && i < 6; i++) begin
      chk($sformatf("rd6_who%0d", i), 32'(who_q[i]), 32'd1);
      chk($sformatf("rd6_data%0d", i), 32'(dat_q[i]), 32'hD000 + 32'(i));
    end

    // M1 two reads then M0 two reads across a grant switch
    do_reset();
    run_reads(2, 2, 2, 0, 3, 12);
    exp_who = '{1, 1, 0, 0};
    chk("mix_rdv_count", 32'(who_q.size()), 32'd4);
    for (int i = 0; i < who_q.size() && i < 4; i++) begin
      chk($sformatf("mix_who%0d", i), 32'(who_q[i]), 32'(exp_who[i]));
      chk($sformatf("mix_data%0d", i), 32'(dat_q[i]), 32'hD000 + 32'(i));
    end

    // Read data with nothing outstanding is dropped and flagged
    do_reset();
    @(negedge Clk);
    s_if.ReadDataValid = 1'b1;
    #1;
    chk("orph_rdv0", 32'(m0_if.ReadDataValid), 32'h0);
    chk("orph_rdv1", 32'(m1_if.ReadDataValid), 32'h0);
    chk("orph_pre", 32'(Orphan_Error), 32'h0);
    @(negedge Clk);
    s_if.ReadDataValid = 1'b0;
    #1;
    chk("orph_set", 32'(Orphan_Error), 32'h1);
    repeat (3) @(negedge Clk);
    #1;
    chk("orph_sticky", 32'(Orphan_Error), 32'h1);

    // Reset with three reads pending, then a late return
    do_reset();
    run_reads(0, 0, 3, 0, 1000, 6);
    chk("rst3_acc1", 32'(acc1), 32'd3);
    do_reset();
    @(negedge Clk); #1;
    chk("rst3_grant", 32'(Grant), 32'h0);
    chk("rst3_orphan_clr", 32'(Orphan_Error), 32'h0);
    chk("rst3_wait1", 32'(m1_if.WaitRequest), 32'h1);
    @(negedge Clk);
    s_if.ReadDataValid = 1'b1;
    s_if.ReadData = 16'hDEAD;
    #1;
    chk("rst3_late_rdv1", 32'(m1_if.ReadDataValid), 32'h0);
    chk("rst3_late_rdv0", 32'(m0_if.ReadDataValid), 32'h0);
    @(negedge Clk);
    s_if.ReadDataValid = 1'b0;
    #1;
    chk("rst3_orphan_set", 32'(Orphan_Error), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
